// File: rtl/square_row_serializer_if.sv
// square_row_serializer_if: square-in / row-out handshake bundle for square_row_serializer.
interface square_row_serializer_if #(parameter int SQSIZE = 16);
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        for (int i = 1; i * i <= n; i++) r = i;
        return r;
    endfunction
    localparam int SIDELEN = isqrt(SQSIZE);
    localparam int IDXW = SIDELEN > 1 ? $clog2(SIDELEN) : 1;
    logic in_valid;
    logic in_ready;
    logic [SQSIZE-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [SIDELEN-1:0] out_row;
    logic [IDXW-1:0] out_idx;
    logic out_last;
    modport master (output in_valid, in_data, out_ready,
                    input in_ready, out_valid, out_row, out_idx, out_last);
    modport slave (input in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_row, out_idx, out_last);
endinterface

// File: rtl/square_row_serializer.sv
// square_row_serializer: buffers one SIDELEN x SIDELEN square and emits it a row per cycle.
// Define SQ_ROW_SER_REVERSE_EN to emit rows in descending index order.
module square_row_serializer #(parameter int SQSIZE = 16) (
    input logic clk,
    input logic rst,
    square_row_serializer_if.slave bus
);
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        for (int i = 1; i * i <= n; i++) r = i;
        return r;
    endfunction
    localparam int SIDELEN = isqrt(SQSIZE);
    localparam int IDXW = SIDELEN > 1 ? $clog2(SIDELEN) : 1;
    localparam int SQBITS = SIDELEN * SIDELEN;
`ifdef SQ_ROW_SER_REVERSE_EN
    localparam logic [IDXW-1:0] FIRST = IDXW'(SIDELEN - 1);
    localparam logic [IDXW-1:0] LAST = '0;
    localparam logic [IDXW-1:0] STEP = '1;
`else
    localparam logic [IDXW-1:0] FIRST = '0;
    localparam logic [IDXW-1:0] LAST = IDXW'(SIDELEN - 1);
    localparam logic [IDXW-1:0] STEP = IDXW'(1);
`endif
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;
    logic [SQBITS-1:0] sq;
    logic [IDXW-1:0] cnt;
    logic load, fin;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    // a final-row transfer with a waiting square reloads in place, so SEND persists
    always_comb begin
        state_nxt = load ? SEND : (fin ? IDLE : state);
    end
    always_comb begin
        bus.out_valid = state == SEND;
        bus.out_last = (SIDELEN == 1) || (state == SEND && cnt == LAST);
        bus.out_idx = cnt;
        bus.out_row = sq[cnt * SIDELEN +: SIDELEN];
        fin = bus.out_valid && bus.out_ready && bus.out_last;
        bus.in_ready = state == IDLE || fin;
        load = bus.in_valid && bus.in_ready;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sq <= '0;
            cnt <= FIRST;
        end else if (load) begin
            sq <= bus.in_data[SQBITS-1:0];
            cnt <= FIRST;
        end else if (bus.out_valid && bus.out_ready && !bus.out_last) begin
            cnt <= cnt + STEP;
        end
endmodule

// File: doc/square_row_serializer.md
# square_row_serializer

Downstream consumer of a flattened SIDELEN x SIDELEN bit square. It accepts one whole square per valid/ready transfer, buffers it, and emits it one row per cycle on a second valid/ready channel. This lets row-oriented logic downstream take squares from the row-reordering stage without a full-width datapath.

## Interface
Parameters:
- SQSIZE, 16, width of the flattened input square in bits
- SIDELEN, derived, largest integer with SIDELEN*SIDELEN <= SQSIZE (16->4, 20->4, 10->3); not overridable
- IDXW, derived, max(1, $clog2(SIDELEN))

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a square
- in_ready  output  1  block will accept a square this cycle
- in_data  input  SQSIZE  flattened square; row r = in_data[r*SIDELEN +: SIDELEN]; bits [SQSIZE-1:SIDELEN*SIDELEN] ignored
- out_valid  output  1  out_row/out_idx/out_last valid
- out_ready  input  1  consumer takes the row this cycle
- out_row  output  SIDELEN  current row
- out_idx  output  IDXW  row index of out_row
- out_last  output  1  final row of the current square

## Operation
- Storage: one SIDELEN*SIDELEN-bit square buffer, row counter cnt (IDXW), one state bit.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SEND: out_valid=1.
- IDLE -> SEND on in_valid&in_ready: capture in_data[SIDELEN*SIDELEN-1:0]; cnt=first index.
- In SEND, an out transfer (out_valid&out_ready) with out_last=0 advances cnt by one step.
- In SEND, an out transfer with out_last=1:
  - If in_valid: capture a new square, reset cnt to the first index, stay in SEND. No bubble.
  - Otherwise: go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). It is combinational from out_ready. It never depends on in_valid.
- Default row order is ascending: first index 0, step +1, out_last when cnt==SIDELEN-1.
- out_row = buffer row cnt; out_idx = cnt.
- While out_valid & !out_ready, out_row, out_idx and out_last hold stable. The buffer is never overwritten during a stall.
- SIDELEN=1: every row has out_last=1. Each square is a single transfer.
- Reset values (asynchronous, while rst=1):
  - state=IDLE, cnt=0, buffer=0.
  - out_valid=0, out_idx=0, out_row=0, out_last=0 (or 1 when SIDELEN=1).
  - in_ready=1 once state is IDLE. in_ready is ignored while rst=1, and no transfer occurs during reset.
- Reset mid-square discards the remaining rows. The square is not re-emitted.

## Timing
- Latency: a square accepted at edge N gives row first-index out_valid after edge N, i.e. in cycle N+1.
- Throughput: one row per cycle with out_ready held high. Back-to-back squares take SIDELEN cycles each, with no idle cycle between them.
- No combinational path from in_valid or in_data to any out_* signal. All out_* signals are registered state.

## Configuration
- SQ_ROW_SER_REVERSE_EN defined: rows are emitted in descending order.
  - First index SIDELEN-1, step -1, out_last when cnt==0.
  - out_idx still reports the true row index.
  - Reset value of cnt becomes SIDELEN-1.
- SQ_ROW_SER_REVERSE_EN undefined: ascending order as described in Operation.
- Handshake, latency and throughput are identical in both builds.

## Test plan
- SQSIZE=16, in_data=16'h4321, out_ready=1:
  - Rows 4'h1, 4'h2, 4'h3, 4'h4 in cycles N+1..N+4.
  - out_idx 0..3; out_last only with idx 3; in_ready=1 in cycle N+4.
- Backpressure, SQSIZE=16, 16'hA5C3:
  - out_ready low for 3 cycles on row 1: out_row holds 4'hC and out_idx=1 throughout.
  - Then rows 4'h5, 4'hA complete; in_ready=0 throughout the stall.
- Back-to-back, SQSIZE=16: squares 16'h1111 then 16'h2222 with in_valid held high.
  - Eight consecutive out transfers: four 4'h1 rows, then four 4'h2 rows.
  - The second square is accepted exactly on the cycle out_last of the first transfers.
- SQSIZE=20, in_data=20'hF_8421:
  - Rows 4'h1, 4'h2, 4'h4, 4'h8; bits [19:16] ignored.
- SQSIZE=10, in_data=10'b11_0101_0110:
  - Rows 3'b110, 3'b010, 3'b101; top bit ignored.
- Reset / reverse build:
  - Assert rst after row 1 of 16'h4321: out_valid=0 immediately; next square starts at idx 0.
  - With SQ_ROW_SER_REVERSE_EN, 16'h4321 yields 4'h4, 4'h3, 4'h2, 4'h1, idx 3..0, out_last with idx 0.
